// File: rtl/dpwm_monitor_if.sv
// +--------------------------------------------------------------------------+
// | dpwm_monitor_if : gate-pair inputs and measurement/fault outputs         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface dpwm_monitor_if #(
    parameter int CNT_W = 11
);
    logic             i_ts_last;
    logic             i_c1;
    logic             i_c2;
    logic             i_clr;
    logic [CNT_W-1:0] o_dt1;
    logic [CNT_W-1:0] o_ton;
    logic [CNT_W-1:0] o_dt2;
    logic [CNT_W-1:0] o_period;
    logic             o_valid;
    logic             o_overlap;
    logic             o_dt_fault;
    logic             o_seq_err;
    logic             o_timeout;

    modport master (
        output i_ts_last, i_c1, i_c2, i_clr,
        input  o_dt1, o_ton, o_dt2, o_period, o_valid,
        input  o_overlap, o_dt_fault, o_seq_err, o_timeout
    );

    modport slave (
        input  i_ts_last, i_c1, i_c2, i_clr,
        output o_dt1, o_ton, o_dt2, o_period, o_valid,
        output o_overlap, o_dt_fault, o_seq_err, o_timeout
    );
endinterface

`default_nettype wire

// File: rtl/dpwm_monitor.sv
// +--------------------------------------------------------------------------+
// | dpwm_monitor : per-period dead-time / on-time measurement and gate faults|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dpwm_monitor #(
    parameter int CNT_W  = 11,
    parameter int MIN_DT = 2,
    parameter int MAX_TS = 1100
) (
    input  wire logic      i_clk,
    input  wire logic      reset_n,
    dpwm_monitor_if.slave  bus
);

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_DT1  = 3'd1;
    localparam logic [2:0] S_TON  = 3'd2;
    localparam logic [2:0] S_DT2  = 3'd3;
    localparam logic [2:0] S_OFF  = 3'd4;

    localparam logic [CNT_W-1:0] C_MIN_DT = CNT_W'(MIN_DT);
    localparam logic [CNT_W-1:0] C_MAX_TS = CNT_W'(MAX_TS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [2:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_dt1, r_ton, r_dt2, r_period;
    logic [CNT_W-1:0] w_dt1_n, w_ton_n, w_dt2_n, w_period_n;
    logic [CNT_W-1:0] r_out_dt1, r_out_ton, r_out_dt2, r_out_period;
    logic             r_valid, r_overlap, r_dt_fault, r_seq_err, r_timeout;
    logic             w_inc_dt1, w_inc_ton, w_inc_dt2, w_seq_set;
    logic             w_active, w_ovl_set, w_report, w_timeout, w_dt_bad;

    assign w_active   = (r_state != S_SYNC);
    assign w_ovl_set  = w_active & bus.i_c1 & bus.i_c2;
    assign w_period_n = sat_inc(r_period);
    assign w_dt1_n    = w_inc_dt1 ? sat_inc(r_dt1) : r_dt1;
    assign w_ton_n    = w_inc_ton ? sat_inc(r_ton) : r_ton;
    assign w_dt2_n    = w_inc_dt2 ? sat_inc(r_dt2) : r_dt2;
    assign w_report   = w_active & bus.i_ts_last;
    assign w_timeout  = w_active & ~bus.i_ts_last & (w_period_n >= C_MAX_TS);
    assign w_dt_bad   = (w_ton_n != '0) && ((w_dt1_n < C_MIN_DT) || (w_dt2_n < C_MIN_DT));

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_SYNC;
        else          r_state <= w_state_nxt;
    end

    // Period boundary and timeout override the per-state transitions.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SYNC:  w_state_nxt = bus.i_ts_last ? S_DT1 : S_SYNC;
            S_DT1:   if (bus.i_c1)      w_state_nxt = S_TON;
                     else if (bus.i_c2) w_state_nxt = S_OFF;
            S_TON:   if (bus.i_c2 && !bus.i_c1) w_state_nxt = S_OFF;
                     else if (!bus.i_c1)        w_state_nxt = S_DT2;
            S_DT2:   if (bus.i_c1 || bus.i_c2)  w_state_nxt = S_OFF;
            S_OFF:   w_state_nxt = S_OFF;
            default: w_state_nxt = S_SYNC;
        endcase
        if (w_report)       w_state_nxt = S_DT1;
        else if (w_timeout) w_state_nxt = S_SYNC;
    end

    // Overlap cycles have c1 high, so they land in the c1 branches.
    always_comb begin
        w_inc_dt1 = 1'b0;
        w_inc_ton = 1'b0;
        w_inc_dt2 = 1'b0;
        w_seq_set = 1'b0;
        case (r_state)
            S_DT1:   if (bus.i_c1) w_inc_ton = 1'b1; else if (!bus.i_c2) w_inc_dt1 = 1'b1;
            S_TON:   if (bus.i_c1) w_inc_ton = 1'b1; else if (!bus.i_c2) w_inc_dt2 = 1'b1;
            S_DT2:   if (bus.i_c1) w_seq_set = 1'b1; else if (!bus.i_c2) w_inc_dt2 = 1'b1;
            S_OFF:   if (bus.i_c1) w_seq_set = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dt1        <= '0;
            r_ton        <= '0;
            r_dt2        <= '0;
            r_period     <= '0;
            r_out_dt1    <= '0;
            r_out_ton    <= '0;
            r_out_dt2    <= '0;
            r_out_period <= '0;
            r_valid      <= 1'b0;
            r_overlap    <= 1'b0;
            r_dt_fault   <= 1'b0;
            r_seq_err    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_valid <= w_report;
            if (w_report) begin
                r_out_dt1    <= w_dt1_n;
                r_out_ton    <= w_ton_n;
                r_out_dt2    <= w_dt2_n;
                r_out_period <= w_period_n;
            end
            if (!w_active || w_report || w_timeout) begin
                r_dt1    <= '0;
                r_ton    <= '0;
                r_dt2    <= '0;
                r_period <= '0;
            end else begin
                r_dt1    <= w_dt1_n;
                r_ton    <= w_ton_n;
                r_dt2    <= w_dt2_n;
                r_period <= w_period_n;
            end
            // A fault raised in the same cycle as the clear survives it.
            r_overlap  <= (r_overlap  & ~bus.i_clr) | w_ovl_set;
            r_dt_fault <= (r_dt_fault & ~bus.i_clr) | (w_report & w_dt_bad);
            r_seq_err  <= (r_seq_err  & ~bus.i_clr) | w_seq_set;
            r_timeout  <= (r_timeout  & ~bus.i_clr) | w_timeout;
        end
    end

    assign bus.o_dt1      = r_out_dt1;
    assign bus.o_ton      = r_out_ton;
    assign bus.o_dt2      = r_out_dt2;
    assign bus.o_period   = r_out_period;
    assign bus.o_valid    = r_valid;
    assign bus.o_overlap  = r_overlap;
    assign bus.o_dt_fault = r_dt_fault;
    assign bus.o_seq_err  = r_seq_err;
    assign bus.o_timeout  = r_timeout;

endmodule

`default_nettype wire
